word_byte_serializer: RTL
=========================

// Module: word_byte_serializer
// PURPOSE
//  Unpacks a parallel word into a stream of bytes, most significant byte first.
//  It is the transmit-side counterpart of the byte-packing shift register.
//  It sits between a word-producing datapath (e.g. memory readout) and a byte-wide
//  consumer, using valid/ready handshakes on both sides.
//  Supports back-to-back words with no idle cycle between them.
// PARAMETERS
//  WORD_BYTES  4  number of bytes per input word (>=2)
//  BYTE_W      8  width of one output byte in bits
// PORTS
//  clk        in   1                   clock, all logic on rising edge
//  reset      in   1                   reset, synchronous, active-high
//  in_word    in   WORD_BYTES*BYTE_W   word to serialize
//  in_valid   in   1                   in_word is valid
//  in_ready   out  1                   block can accept in_word this cycle
//  out_byte   out  BYTE_W              current byte (MSB of held word)
//  out_valid  out  1                   out_byte is valid
//  out_ready  in   1                   consumer accepts out_byte this cycle
//  out_last   out  1                   out_byte is final byte of its word
//  busy       out  1                   a word is being serialized (== out_valid)
// BEHAVIOUR
//  State machine states:
//  - IDLE: no word is held. out_valid=0, in_ready=1.
//  - SEND: a word is held in shreg. out_valid=1, out_byte=shreg[top BYTE_W bits].
//  Input acceptance:
//  - Input handshake = in_valid & in_ready, sampled on the clock edge.
//  - IDLE + handshake: shreg<=in_word, cnt<=0, go to SEND.
//  - The first byte appears on the cycle after acceptance (latency 1).
//  Output transfer:
//  - Output handshake = out_valid & out_ready.
//  - On an output handshake with cnt<WORD_BYTES-1: shreg<=shreg<<BYTE_W (zero fill), cnt<=cnt+1.
//  - out_last = SEND & (cnt==WORD_BYTES-1).
//  Last-byte handshake:
//  - in_ready = IDLE | (SEND & out_last & out_ready); this is combinational from out_ready.
//  - Last-byte handshake with in_valid=1: load the new word, cnt<=0, stay in SEND.
//    No bubble between words.
//  - Last-byte handshake with in_valid=0: go to IDLE.
//  Backpressure:
//  - While out_valid & !out_ready, out_byte, out_last and cnt hold stable.
//  - No byte is ever dropped or duplicated.
//  Counter:
//  - cnt width is clog2(WORD_BYTES). cnt never exceeds WORD_BYTES-1 and never wraps.
//  Reset:
//  - Reset values: state=IDLE, shreg=0, cnt=0, out_byte=0, out_valid=0, out_last=0, busy=0.
//  - in_ready=1 from the first cycle after reset.
//  - Reset mid-word discards the remaining bytes and any word presented that cycle.
//  - Reset has priority over every handshake.
//  Stability rule:
//  - in_word is sampled only on an input handshake.
//  - Changes to in_word at any other time have no effect.
// CONFIGURATION
//  SER_PARITY_EN defined:
//  - Adds output port out_parity (1 bit).
//  - out_parity = ^out_byte (even parity), valid whenever out_valid=1, 0 after reset.
//  - It follows out_byte in the same cycle.
//  SER_PARITY_EN undefined:
//  - The out_parity port and its logic are absent.
//  - All other behaviour is identical.
// TESTING
//  1. Single word: in_word=0xDEADBEEF, out_ready=1 -> bytes DE,AD,BE,EF on 4 consecutive cycles.
//     out_last=1 only with EF; IDLE afterwards.
//  2. Backpressure: 0x11223344, out_ready low for 3 cycles while 0x22 is shown
//     -> 0x22 held stable, then 33,44 follow; total of 4 output handshakes.
//  3. Back-to-back: 0xA1A2A3A4 then 0xB1B2B3B4 offered on A4's handshake cycle
//     -> in_ready=1 that cycle; B1 follows A4 with no gap.
//  4. Idle input: no in_valid after 0x01020304 -> out_valid=0 after byte 04.
//     in_word toggling while idle causes no output.
//  5. Reset mid-word: assert reset after byte 0xAD of 0xDEADBEEF
//     -> next cycle out_valid=0, out_byte=0, in_ready=1; the next word starts fresh at its MSB.
//  6. SER_PARITY_EN: stream 0x0103FF80 -> out_parity = 1,0,0,1.
//     Build without the macro compiles with the port absent.

Source files
------------

// File: rtl/word_byte_serializer.sv
// word_byte_serializer: unpacks a WORD_BYTES x BYTE_W word into a byte stream,
// most significant byte first, with valid/ready handshakes on both sides.
// Back-to-back words stream without a bubble: a new word may be loaded on the
// same cycle the last byte of the current word is accepted.
// Optional feature: define SER_PARITY_EN to add out_parity (even parity of out_byte).
module word_byte_serializer #(
    parameter int unsigned WORD_BYTES = 4,
    parameter int unsigned BYTE_W     = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [WORD_BYTES*BYTE_W-1:0] in_word,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic [BYTE_W-1:0]            out_byte,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         out_last,
    output logic                         busy
`ifdef SER_PARITY_EN
    ,
    output logic                         out_parity
`endif
);

    localparam int unsigned WORD_W = WORD_BYTES * BYTE_W;
    localparam int unsigned CNT_W  = $clog2(WORD_BYTES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORD_BYTES - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t            state, state_n;
    logic [WORD_W-1:0] shreg, shreg_n;
    logic [CNT_W-1:0]  cnt, cnt_n;

    // Output decode: the held word's top byte is always presented.
    always_comb begin
        out_valid = (state == SEND);
        out_last  = (state == SEND) && (cnt == CNT_LAST);
        in_ready  = (state == IDLE) || ((state == SEND) && (cnt == CNT_LAST) && out_ready);
        out_byte  = shreg[WORD_W-1 -: BYTE_W];
        busy      = (state == SEND);
    end

`ifdef SER_PARITY_EN
    // Even parity tracks out_byte combinationally; shreg resets to 0 so this resets to 0.
    always_comb begin
        out_parity = ^out_byte;
    end
`endif

    // Next-state logic: load on input handshake, shift on non-final output handshake.
    always_comb begin
        state_n = state;
        shreg_n = shreg;
        cnt_n   = cnt;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    shreg_n = in_word;
                    cnt_n   = '0;
                    state_n = SEND;
                end
            end
            SEND: begin
                if (out_ready) begin
                    if (cnt == CNT_LAST) begin
                        if (in_valid) begin
                            shreg_n = in_word;
                            cnt_n   = '0;
                        end else begin
                            state_n = IDLE;
                        end
                    end else begin
                        shreg_n = shreg << BYTE_W;
                        cnt_n   = cnt + 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State register; reset overrides any handshake in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            shreg <= '0;
            cnt   <= '0;
        end else begin
            state <= state_n;
            shreg <= shreg_n;
            cnt   <= cnt_n;
        end
    end

endmodule
